// File: rtl/memory_unit_if.sv
// Core-side bus for memory_unit: instruction fetch (port A) and load/store (port B).
// The master modport is the core datapath, the slave modport is the memory block.
interface memory_unit_if;
    logic [31:0] AddressA;
    logic [31:0] ReadDataA;
    logic        IsExcept;
    logic [31:0] AddressB;
    logic [31:0] WriteData;
    logic        EnableWriteB;
    logic [31:0] ReadDataB;
    logic        IsMMIO;

    modport master (
        output AddressA, AddressB, WriteData, EnableWriteB,
        input  ReadDataA, ReadDataB, IsExcept, IsMMIO
    );

    modport slave (
        input  AddressA, AddressB, WriteData, EnableWriteB,
        output ReadDataA, ReadDataB, IsExcept, IsMMIO
    );
endinterface

// File: rtl/memory_unit.sv
// Unified dual-port word memory with an MMIO window on port B and VGA text buffer.
// Define EXCEPT_HANDLER_EN to map the exception-handler ROM window onto port A.
module memory_unit #(
    parameter int MEM_DEPTH_LOG2 = 14,
    parameter int VGA_AW         = 11
) (
    input  logic              clk,
    input  logic              reset,
    memory_unit_if.slave      bus,
    input  logic [7:0]        Switch1,
    input  logic [7:0]        Switch2,
    input  logic              Button1,
    input  logic              Button2,
    input  logic              Button3,
    input  logic              Button4,
    input  logic              Button5,
    input  logic [VGA_AW-1:0] VgaAddress,
    output logic [31:0]       Seg1Out,
    output logic [7:0]        Led1Out,
    output logic [7:0]        Led2Out,
    output logic [7:0]        CharOut,
    output logic [7:0]        ColorOut
);
    localparam int MEM_WORDS = 1 << MEM_DEPTH_LOG2;
    localparam int VGA_CELLS = 1 << VGA_AW;

    logic [31:0] mem [0:MEM_WORDS-1];
    logic [15:0] vga_mem [0:VGA_CELLS-1];

    logic [MEM_DEPTH_LOG2-1:0] index_a;
    logic [MEM_DEPTH_LOG2-1:0] index_b;
    logic [VGA_AW-1:0]         vga_index;
    logic [15:0]               mmio_offset;
    logic                      is_mmio;
    logic                      vga_hit;
    logic [31:0]               mmio_rdata;
    logic                      unused_bits;

    assign index_a     = bus.AddressA[MEM_DEPTH_LOG2+1:2];
    assign index_b     = bus.AddressB[MEM_DEPTH_LOG2+1:2];
    assign mmio_offset = bus.AddressB[15:0];
    assign is_mmio     = (bus.AddressB[31:16] == 16'hFFFF);
    assign vga_index   = bus.AddressB[VGA_AW+1:2];
    assign vga_hit     = (bus.AddressB[15:VGA_AW+2] == '0);
    assign unused_bits = ^{bus.AddressA[31:MEM_DEPTH_LOG2+2], bus.AddressA[1:0], bus.AddressB[1:0]};

    assign bus.IsMMIO = is_mmio;
    assign Led1Out    = Switch1;
    assign {ColorOut, CharOut} = vga_mem[VgaAddress];

`ifdef EXCEPT_HANDLER_EN
    function automatic logic [31:0] handler_rom(input logic [5:0] word);
        case (word)
            6'd0:    handler_rom = 32'hFF810113;
            default: handler_rom = 32'h00000013;
        endcase
    endfunction

    assign bus.IsExcept  = (bus.AddressA[31:8] == 24'h1C0900);
    assign bus.ReadDataA = bus.IsExcept ? handler_rom(bus.AddressA[7:2]) : mem[index_a];
`else
    assign bus.IsExcept  = 1'b0;
    assign bus.ReadDataA = mem[index_a];
`endif

    // Unmapped and out-of-range VGA offsets fall through to zero.
    always_comb begin
        mmio_rdata = 32'h0;
        case (mmio_offset)
            16'hFF00: mmio_rdata = {24'h0, Switch1};
            16'hFF04: mmio_rdata = {24'h0, Switch2};
            16'hFF08: mmio_rdata = {31'h0, Button1};
            16'hFF0C: mmio_rdata = {31'h0, Button2};
            16'hFF10: mmio_rdata = {31'h0, Button3};
            16'hFF14: mmio_rdata = {31'h0, Button4};
            16'hFF18: mmio_rdata = {31'h0, Button5};
            16'hFF20: mmio_rdata = Seg1Out;
            16'hFF24: mmio_rdata = {24'h0, Led2Out};
            default:  if (vga_hit) mmio_rdata = {16'h0, vga_mem[vga_index]};
        endcase
    end

    assign bus.ReadDataB = is_mmio ? mmio_rdata : mem[index_b];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Seg1Out <= 32'h0;
            Led2Out <= 8'h0;
        end else if (bus.EnableWriteB && is_mmio) begin
            if (mmio_offset == 16'hFF20) Seg1Out <= bus.WriteData;
            if (mmio_offset == 16'hFF24) Led2Out <= bus.WriteData[7:0];
        end
    end

    // Storage arrays are never cleared; a write needs reset released at the edge.
    always_ff @(posedge clk) begin
        if (reset && bus.EnableWriteB) begin
            if (!is_mmio)
                mem[index_b] <= bus.WriteData;
            else if (vga_hit)
                vga_mem[vga_index] <= bus.WriteData[15:0];
        end
    end
endmodule

// File: tb/tb_memory_unit.sv
// Directed scoreboard bench for memory_unit: expectations are queued as stimulus
// is driven and popped as each DUT output is sampled.
module tb_memory_unit;
    logic        clk;
    logic        reset;
    logic [7:0]  switch1, switch2;
    logic        button1, button2, button3, button4, button5;
    logic [10:0] vga_address;
    logic [31:0] seg1_out;
    logic [7:0]  led1_out, led2_out, char_out, color_out;

    memory_unit_if bus ();

    memory_unit #(.MEM_DEPTH_LOG2(14), .VGA_AW(11)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .Switch1(switch1), .Switch2(switch2),
        .Button1(button1), .Button2(button2), .Button3(button3),
        .Button4(button4), .Button5(button5),
        .VgaAddress(vga_address),
        .Seg1Out(seg1_out), .Led1Out(led1_out), .Led2Out(led2_out),
        .CharOut(char_out), .ColorOut(color_out)
    );

    typedef struct {
        string       tag;
        logic [31:0] value;
    } expect_t;

    expect_t sb[$];
    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_expect(input string tag, input logic [31:0] value);
        expect_t e;
        e.tag   = tag;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic check_output(input logic [31:0] observed);
        expect_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("[TB] FAIL scoreboard_empty: observed 0x%08h, no expected value queued", observed);
        end else begin
            e = sb.pop_front();
            assert (observed === e.value) else begin
                failures++;
                $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", e.tag, observed, e.value);
            end
        end
    endtask

    // One store on port B, held for exactly one rising edge.
    task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] data);
        bus.AddressB     = addr;
        bus.WriteData    = data;
        bus.EnableWriteB = 1'b1;
        @(posedge clk);
        #1;
        bus.EnableWriteB = 1'b0;
    endtask

    task automatic read_b(input logic [31:0] addr, input string tag, input logic [31:0] value);
        bus.AddressB = addr;
        push_expect(tag, value);
        #1;
        check_output(bus.ReadDataB);
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        bus.AddressA = 32'h0; bus.AddressB = 32'h0;
        bus.WriteData = 32'h0; bus.EnableWriteB = 1'b0;
        switch1 = 8'h0; switch2 = 8'h0;
        {button1, button2, button3, button4, button5} = 5'b0;
        vga_address = '0;

        #2;
        push_expect("reset_seg1", 32'h0);
        push_expect("reset_led2", 32'h0);
        check_output(seg1_out);
        check_output({24'h0, led2_out});
        @(negedge clk);
        reset = 1'b1;
        #2;

        apply_stimulus(32'h0000_0000, 32'h0000_0000);
        apply_stimulus(32'h0000_0004, 32'h1234_5678);
        read_b(32'h0000_0004, "mem_read_w4", 32'h1234_5678);
        push_expect("ismmio_low", 32'h0);
        check_output({31'h0, bus.IsMMIO});

        // Port A sees old data before the store edge and new data after it.
        apply_stimulus(32'h0000_0008, 32'h1111_1111);
        bus.AddressA = 32'h0000_0008;
        bus.AddressB = 32'h0000_0008;
        bus.WriteData = 32'h2222_2222;
        bus.EnableWriteB = 1'b1;
        push_expect("porta_before_edge", 32'h1111_1111);
        #1;
        check_output(bus.ReadDataA);
        @(posedge clk);
        #1;
        bus.EnableWriteB = 1'b0;
        push_expect("porta_after_edge", 32'h2222_2222);
        check_output(bus.ReadDataA);

        switch1 = 8'h0A; switch2 = 8'h5C; button1 = 1'b1; button5 = 1'b1;
        read_b(32'hFFFF_FF00, "mmio_switch1", 32'h0000_000A);
        push_expect("ismmio_high", 32'h1);
        check_output({31'h0, bus.IsMMIO});
        push_expect("led1_echo", 32'h0000_000A);
        check_output({24'h0, led1_out});
        read_b(32'hFFFF_FF08, "mmio_button1", 32'h0000_0001);
        read_b(32'hFFFF_FF04, "mmio_switch2", 32'h0000_005C);
        read_b(32'hFFFF_FF0C, "mmio_button2", 32'h0000_0000);
        read_b(32'hFFFF_FF18, "mmio_button5", 32'h0000_0001);

        bus.AddressA = 32'h1C09_0000;
`ifdef EXCEPT_HANDLER_EN
        push_expect("except_flag", 32'h1);
        push_expect("except_rom_w0", 32'hFF81_0113);
`else
        push_expect("except_flag", 32'h0);
        push_expect("except_alias_w0", 32'h0000_0000);
`endif
        #1;
        check_output({31'h0, bus.IsExcept});
        check_output(bus.ReadDataA);
        bus.AddressA = 32'h0000_0004;
        push_expect("fetch_flag", 32'h0);
        push_expect("fetch_w4", 32'h1234_5678);
        #1;
        check_output({31'h0, bus.IsExcept});
        check_output(bus.ReadDataA);

        // VGA cells: first, an interior one, last; one past the end is unmapped.
        apply_stimulus(32'hFFFF_0000, 32'h8765_4321);
        read_b(32'h0000_0000, "mem_w0_untouched", 32'h0000_0000);
        vga_address = 11'd0;
        push_expect("vga0_char", 32'h21);
        push_expect("vga0_color", 32'h43);
        #1;
        check_output({24'h0, char_out});
        check_output({24'h0, color_out});
        read_b(32'hFFFF_0000, "vga0_readback", 32'h0000_4321);
        apply_stimulus(32'hFFFF_0014, 32'h0000_AABB);
        vga_address = 11'd5;
        push_expect("vga5_cell", 32'h0000_AABB);
        #1;
        check_output({16'h0, color_out, char_out});
        apply_stimulus(32'hFFFF_1FFC, 32'h0000_7E7F);
        vga_address = 11'd2047;
        push_expect("vga_last_cell", 32'h0000_7E7F);
        #1;
        check_output({16'h0, color_out, char_out});
        apply_stimulus(32'hFFFF_2000, 32'h0000_5555);
        read_b(32'hFFFF_2000, "vga_past_end", 32'h0000_0000);
        read_b(32'hFFFF_0000, "vga0_no_alias", 32'h0000_4321);

        apply_stimulus(32'hFFFF_FF20, 32'h0000_1234);
        push_expect("seg1_written", 32'h0000_1234);
        check_output(seg1_out);
        read_b(32'hFFFF_FF20, "seg1_readback", 32'h0000_1234);
        apply_stimulus(32'hFFFF_FF24, 32'h0000_01A5);
        push_expect("led2_written", 32'h0000_00A5);
        check_output({24'h0, led2_out});
        read_b(32'hFFFF_FF24, "led2_readback", 32'h0000_00A5);
        read_b(32'hFFFF_FF30, "mmio_unmapped", 32'h0000_0000);

        apply_stimulus(32'h0000_FF00, 32'h0BAD_BEEF);
        apply_stimulus(32'hFFFF_FF00, 32'hFFFF_FFFF);
        read_b(32'hFFFF_FF00, "switch1_readonly", 32'h0000_000A);
        read_b(32'h0000_FF00, "mmio_no_mem_write", 32'h0BAD_BEEF);

        // Asynchronous reset mid-cycle, then a store attempted while held low.
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        push_expect("async_reset_seg1", 32'h0);
        push_expect("async_reset_led2", 32'h0);
        check_output(seg1_out);
        check_output({24'h0, led2_out});
        switch1 = 8'h3C;
        push_expect("led1_during_reset", 32'h0000_003C);
        #1;
        check_output({24'h0, led1_out});
        apply_stimulus(32'h0000_0004, 32'hDEAD_DEAD);
        apply_stimulus(32'hFFFF_FF20, 32'hDEAD_DEAD);
        push_expect("seg1_write_in_reset", 32'h0);
        check_output(seg1_out);
        @(negedge clk);
        reset = 1'b1;
        #1;
        read_b(32'h0000_0004, "mem_write_in_reset", 32'h1234_5678);
        read_b(32'hFFFF_0000, "vga_kept_over_reset", 32'h0000_4321);

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_leftover: %0d entries remain, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule

// File: doc/memory_unit.md
# memory_unit

Unified memory block for the single-cycle RISC-V core: a dual-port word memory serving instruction fetch (port A) and load/store (port B), a memory-mapped I/O window on port B, and a fixed exception-handler ROM window on port A. It sits between the core datapath and the board I/O (switches, buttons, LEDs, 7-segment display, VGA text buffer).

## Interface
- MEM_DEPTH_LOG2, 14, main memory depth in 32-bit words (index = address[MEM_DEPTH_LOG2+1:2])
- VGA_AW, 11, VGA text-buffer address width (2^VGA_AW cells)
- clk  in  1  single clock; all writes on rising edge
- reset  in  1  asynchronous, active-low reset
- AddressA  in  32  instruction fetch byte address
- AddressB  in  32  load/store byte address
- WriteData  in  32  store data
- EnableWriteB  in  1  store strobe for port B
- Switch1, Switch2  in  8  board switches
- Button1..Button5  in  1  board buttons (already debounced)
- VgaAddress  in  VGA_AW  VGA controller cell index
- Seg1Out  out  32  7-segment display value register
- Led1Out, Led2Out  out  8  LED banks
- CharOut, ColorOut  out  8  char/color of cell VgaAddress
- ReadDataA  out  32  fetch data
- ReadDataB  out  32  load data
- IsMMIO  out  1  AddressB[31:16] == 16'hFFFF
- IsExcept  out  1  AddressA in exception window

## Operation
- Address bits [1:0] ignored on both ports (word access only).
- Port A: IsExcept = (AddressA[31:8] == 24'h1C0900). If IsExcept, ReadDataA = handler ROM[AddressA[7:2]]; else main memory word.
- Handler ROM: 64 words, constant; word 0 = 0xFF810113 (addi sp,sp,-8); remaining words per the exception-handler listing; unlisted words = 0x00000013 (nop).
- Port B, non-MMIO: ReadDataB = main memory word; EnableWriteB writes WriteData at next rising clk.
- Port B, MMIO (IsMMIO=1): main memory never written. Decode on AddressB[15:0]:
  - 0xFF00 Switch1 (R, zero-extended); 0xFF04 Switch2 (R)
  - 0xFF08/0C/10/14/18 Button1..5 (R, bit 0)
  - 0xFF20 Seg1Out (R/W, 32 bits)
  - 0xFF24 Led2Out (R/W, low 8 bits stored)
  - 0x0000 + 4*i, i < 2^VGA_AW: VGA cell i (W: [15:8]=color, [7:0]=char; R: {16'b0,color,char})
  - any other MMIO address: reads 0, writes ignored; writes to read-only registers ignored.
- Led1Out = Switch1 continuously (switch echo).
- CharOut/ColorOut = VGA cell VgaAddress, combinational.

## Timing
- All reads (main memory, ROM, MMIO, VGA) combinational from address; no read latency.
- Writes (memory, Seg1Out, Led2Out, VGA cell) take effect on rising clk when EnableWriteB=1; visible on reads immediately after that edge.
- Same-address read on port A during port-B write: old data before the edge, new after.
- reset low (async): Seg1Out=0, Led2Out=0 immediately; main memory, VGA buffer not cleared; combinational outputs follow inputs. Write strobes ignored while reset low.
- Reset deasserted mid-write cycle: write occurs only on a rising edge with reset high.

## Configuration
- EXCEPT_HANDLER_EN defined: exception window and ROM as above.
- Not defined: IsExcept tied 0; AddressA always reads main memory (0x1C09_0000 aliases into main memory by index bits).

## Test plan
- Write 0x12345678 to 0x0000_0004 with EnableWriteB, then read 0x0000_0004 -> ReadDataB = 0x12345678, IsMMIO=0.
- AddressB=0xFFFF_FF00, Switch1=0x0A, Button1=1 -> IsMMIO=1, ReadDataB=0x0000000A, Led1Out=0x0A; AddressB=0xFFFF_FF08 -> ReadDataB=0x00000001.
- AddressA=0x1C09_0000 -> IsExcept=1, ReadDataA=0xFF810113; AddressA=0x0000_0004 -> IsExcept=0, ReadDataA=0x12345678.
- Write 0x87654321 to 0xFFFF_0000 -> main memory word 0 unchanged (0), VgaAddress=0 gives CharOut=0x21, ColorOut=0x43.
- Write 0x00001234 to 0xFFFF_FF20 -> Seg1Out=0x00001234; assert reset low asynchronously -> Seg1Out=0 without clock edge.
- Write to 0xFFFF_FF00 -> ignored, ReadDataB still returns Switch1.
